// File: rtl/ram8_pkg.sv
// Shared sizing and FSM state encoding for the ram8 sequencer and its RAM.
package ram8_pkg;
    localparam int WIDTH  = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
endpackage

// File: rtl/ram8.sv
// Small single-port RAM: combinational read, write on the rising clock edge.
module ram8 #(
    parameter int WIDTH  = ram8_pkg::WIDTH,
    parameter int DEPTH  = ram8_pkg::DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  d,
    input  logic              load,
    output logic [WIDTH-1:0]  q
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (load) mem[address] <= d;
    end

    assign q = mem[address];
endmodule

// File: rtl/ram8_sequencer.sv
// Command-driven block mover between a ram8 and a pair of valid/ready streams:
// fill streams words into consecutive RAM addresses, dump streams them back out.
module ram8_sequencer import ram8_pkg::*; #(
    parameter int WIDTH  = ram8_pkg::WIDTH,
    parameter int DEPTH  = ram8_pkg::DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_count,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [WIDTH-1:0]  ram_in,
    output logic              ram_load,
    input  logic [WIDTH-1:0]  ram_out,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr, addr_inc;
    logic [ADDR_W:0]   remaining, count_sat;
    logic              rd_capture;

    assign count_sat   = (cmd_count > DEPTH_CNT) ? DEPTH_CNT : cmd_count;
    assign addr_inc    = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    assign ram_address = addr;
    assign ram_in      = wr_data;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    // The output register may refill in the same cycle its word is taken.
    assign rd_capture  = (state == READ) && (remaining != '0) && (!rd_valid || rd_ready);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        ram_load  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (count_sat == '0) state_nx = DONE;
                    else if (cmd_write)  state_nx = WRITE;
                    else                 state_nx = READ;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                // Gated by reset so an asserting reset kills the strobe before any edge.
                ram_load = wr_valid && reset_n;
                if (wr_valid && remaining == (ADDR_W+1)'(1)) state_nx = DONE;
            end
            READ: begin
                if (remaining == '0 && rd_valid && rd_ready) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr      <= '0;
            remaining <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr      <= cmd_base;
                        remaining <= count_sat;
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        addr      <= addr_inc;
                        remaining <= remaining - 1'b1;
                    end
                end
                READ: begin
                    if (rd_capture) begin
                        rd_data   <= ram_out;
                        rd_valid  <= 1'b1;
                        addr      <= addr_inc;
                        remaining <= remaining - 1'b1;
                    end else if (rd_ready) begin
                        rd_valid  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ram8_sequencer.sv
// Randomized self-checking bench: sequencer driving a real ram8, checked against an array model.
module tb_ram8_sequencer;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [2:0]  cmd_base;
    logic [3:0]  cmd_count;
    logic [15:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid, rd_ready;
    logic [2:0]  ram_address;
    logic [15:0] ram_in, ram_out;
    logic        ram_load, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] model_mem [8];

    ram8_sequencer dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out),
        .busy(busy), .done(done)
    );

    ram8 u_ram (
        .clock(clock), .address(ram_address), .d(ram_in), .load(ram_load), .q(ram_out)
    );

    always #5 clock = ~clock;

    task automatic do_cmd(input bit wr, input int base, input int cnt);
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_base  = 3'(base);
        cmd_count = 4'(cnt);
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cmd_accept: cmd_ready=%b busy=%b, want 1 0", cmd_ready, busy);
        end
        @(posedge clock);
    endtask

    task automatic finish_cmd(input string tag);
        @(negedge clock);
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        rd_ready  = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0 || ram_load !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: done=%b busy=%b cmd_ready=%b load=%b, want 1 1 0 0",
                     tag, done, busy, cmd_ready, ram_load);
        end
        @(negedge clock);
        #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle: done=%b busy=%b cmd_ready=%b, want 0 0 1", tag, done, busy, cmd_ready);
        end
    endtask

    task automatic do_fill(input int base, input int cnt, input bit fixed, input bit gaps);
        int n, i, cyc;
        logic [15:0] dat;
        n   = (cnt > 8) ? 8 : cnt;
        i   = 0;
        cyc = 0;
        dat = fixed ? 16'h1111 : 16'($urandom);
        do_cmd(1'b1, base, cnt);
        while (i < n && cyc < 200) begin
            @(negedge clock);
            cyc++;
            cmd_valid = 1'b0;
            wr_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            wr_data   = wr_valid ? dat : 16'($urandom);
            #1;
            n_checks++;
            if (wr_ready !== 1'b1 || ram_load !== wr_valid || ram_in !== wr_data
                || ram_address !== 3'((base + i) % 8) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_word%0d: ready=%b load=%b in=%h addr=%0d done=%b, want 1 %b %h %0d 0",
                         i, wr_ready, ram_load, ram_in, ram_address, done, wr_valid, wr_data, (base + i) % 8);
            end
            if (wr_valid) begin
                model_mem[(base + i) % 8] = dat;
                i++;
                dat = fixed ? 16'((i + 1) * 16'h1111) : 16'($urandom);
            end
        end
        if (i < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL fill_timeout: accepted %0d words, want %0d", i, n);
        end
        finish_cmd("fill");
    endtask

    // mode 0: rd_ready held high, 1: pattern 1,0,0 repeating, 2: random
    task automatic do_dump(input int base, input int cnt, input int mode);
        int n, j, cyc;
        logic [15:0] exp_q [$];
        logic [15:0] held;
        bit stalled;
        n = (cnt > 8) ? 8 : cnt;
        for (int k = 0; k < n; k++) exp_q.push_back(model_mem[(base + k) % 8]);
        j       = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        do_cmd(1'b0, base, cnt);
        while (j < n && cyc < 200) begin
            @(negedge clock);
            cyc++;
            cmd_valid = 1'b0;
            wr_valid  = 1'($urandom_range(0, 1));
            wr_data   = 16'($urandom);
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = ((cyc - 1) % 3 == 0);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            n_checks++;
            if (ram_load !== 1'b0 || wr_ready !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL dump_quiet: load=%b wr_ready=%b done=%b, want 0 0 0", ram_load, wr_ready, done);
            end
            if (stalled) begin
                n_checks++;
                if (rd_valid !== 1'b1 || rd_data !== held) begin
                    n_fail++;
                    $display("FAIL dump_hold: valid=%b data=%h, want 1 %h", rd_valid, rd_data, held);
                end
            end
            if (mode == 0) begin
                n_checks++;
                if (rd_valid !== 1'(cyc >= 2)) begin
                    n_fail++;
                    $display("FAIL dump_latency: cycle %0d valid=%b, want %b", cyc, rd_valid, cyc >= 2);
                end
            end
            if (rd_valid === 1'b1 && rd_ready) begin
                n_checks++;
                if (rd_data !== exp_q[j]) begin
                    n_fail++;
                    $display("FAIL dump_word%0d: data=%h, want %h", j, rd_data, exp_q[j]);
                end
                j++;
            end
            stalled = (rd_valid === 1'b1) && !rd_ready;
            held    = rd_data;
        end
        if (j < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL dump_timeout: got %0d words, want %0d", j, n);
        end
        finish_cmd("dump");
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_base  = '0;
        cmd_count = '0;
        wr_data   = '0;
        wr_valid  = 1'b0;
        rd_ready  = 1'b0;
        #2;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 16'h0
            || ram_load !== 1'b0 || ram_address !== 3'd0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b rd_valid=%b rd_data=%h load=%b addr=%0d cmd_ready=%b",
                     busy, done, rd_valid, rd_data, ram_load, ram_address, cmd_ready);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b, want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_fill_basic();
        do_fill(0, 8, 1'b0, 1'b0);   // give every RAM word a known value
        do_fill(2, 4, 1'b1, 1'b0);
        do_dump(0, 8, 0);
    endtask

    task automatic test_dump_wrap();
        do_dump(6, 4, 0);
    endtask

    task automatic test_dump_stall();
        do_dump(5, 7, 1);
        do_dump(1, 8, 1);
    endtask

    task automatic test_count_zero_and_saturation();
        do_fill(3, 0, 1'b0, 1'b1);
        do_dump(5, 0, 0);
        do_fill(1, 12, 1'b0, 1'b1);
        do_dump(4, 15, 2);
    endtask

    task automatic test_reset_mid_fill();
        logic [15:0] dat;
        int i, cyc;
        bit bad_done;
        i   = 0;
        cyc = 0;
        do_cmd(1'b1, 0, 8);
        while (i < 3 && cyc < 50) begin
            @(negedge clock);
            cyc++;
            cmd_valid = 1'b0;
            wr_valid  = 1'b1;
            dat       = 16'($urandom);
            wr_data   = dat;
            #1;
            if (i == 2) begin
                n_checks++;
                if (ram_load !== 1'b1) begin
                    n_fail++;
                    $display("FAIL midfill_preload: load=%b, want 1", ram_load);
                end
                reset_n = 1'b0;
                #1;
                n_checks++;
                if (ram_load !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0
                    || ram_address !== 3'd0 || cmd_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL midfill_reset: load=%b busy=%b done=%b rd_valid=%b addr=%0d cmd_ready=%b",
                             ram_load, busy, done, rd_valid, ram_address, cmd_ready);
                end
                i = 3;
            end else begin
                model_mem[i] = dat;
                i++;
            end
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (ram_load !== 1'b0) begin
            n_fail++;
            $display("FAIL midfill_held: load=%b, want 0", ram_load);
        end
        @(negedge clock);
        reset_n  = 1'b1;
        wr_valid = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midfill_release: cmd_ready=%b, want 1", cmd_ready);
        end
        bad_done = 1'b0;
        repeat (4) begin
            @(negedge clock);
            #1;
            if (done !== 1'b0) bad_done = 1'b1;
        end
        n_checks++;
        if (bad_done) begin
            n_fail++;
            $display("FAIL midfill_no_done: done pulsed after reset, want none");
        end
        do_dump(0, 8, 2);
    endtask

    task automatic test_random();
        repeat (8) begin
            if ($urandom_range(0, 1) == 1) do_fill($urandom_range(0, 7), $urandom_range(0, 15), 1'b0, 1'b1);
            else                           do_dump($urandom_range(0, 7), $urandom_range(0, 15), 2);
        end
        do_dump(0, 8, 0);
    endtask

    initial begin
        test_reset();
        test_fill_basic();
        test_dump_wrap();
        test_dump_stall();
        test_count_zero_and_saturation();
        test_reset_mid_fill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
